// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: the operation encoding
// and a helper that classifies the operations that advance the bit counter.
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD  = 3'd0,
        USR_SHL   = 3'd1,
        USR_SHR   = 3'd2,
        USR_LOAD  = 3'd3,
        USR_ROL   = 3'd4,
        USR_ROR   = 3'd5,
        USR_CLEAR = 3'd6,
        USR_RSVD  = 3'd7
    } usr_mode_e;

    function automatic logic usr_is_shift(input usr_mode_e mode);
        return (mode == USR_SHL) || (mode == USR_SHR) ||
               (mode == USR_ROL) || (mode == USR_ROR);
    endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// Modulo-MAX operation counter with a registered pulse on the cycle after wrap.
// clr has priority over inc and always suppresses the pulse.
module usr_bit_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap_pulse
);

    // Wrap at MAX-1 explicitly so non-power-of-two widths never reach 2^W-1.
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_reg, cnt_next;
    logic         wrap_reg, wrap_next;

    always_comb begin
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            if (cnt_reg == LAST) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            wrap_reg <= wrap_next;
        end
    end

    assign cnt        = cnt_reg;
    assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold / shift left-right / load / rotate / clear,
// with an operation counter that pulses once per WIDTH shifts or rotates.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [63:0] RESET_VAL = 64'd0,
    localparam int         CNT_W     = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout_msb,
    output logic             o_sout_lsb,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_frame_done
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    usr_mode_e        mode;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             do_shift;
    logic             do_restart;

    assign mode = usr_mode_e'(i_mode);

    always_comb begin
        q_next = q_reg;
        if (i_en) begin
            case (mode)
                USR_SHL:   q_next = {q_reg[WIDTH-2:0], i_sin};
                USR_SHR:   q_next = {i_sin, q_reg[WIDTH-1:1]};
                USR_LOAD:  q_next = i_pdata;
                USR_ROL:   q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                USR_ROR:   q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                USR_CLEAR: q_next = '0;
                default:   q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_reg <= RST_Q;
        end else begin
            q_reg <= q_next;
        end
    end

    // LOAD and CLEAR start a fresh frame; only shifts and rotates advance it.
    assign do_shift   = i_en && usr_is_shift(mode);
    assign do_restart = i_en && ((mode == USR_LOAD) || (mode == USR_CLEAR));

    usr_bit_counter #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_bit_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .inc        (do_shift),
        .clr        (do_restart),
        .cnt        (o_bit_cnt),
        .wrap_pulse (o_frame_done)
    );

    assign o_q        = q_reg;
    assign o_sout_msb = q_reg[WIDTH-1];
    assign o_sout_lsb = q_reg[0];

    a_mode_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_en |-> !$isunknown(i_mode));

endmodule

// File: tb/tb_usr_shift_reg.sv
// Bench for usr_shift_reg: three widths (4, 8, 5) driven in lockstep and checked
// against an arithmetic reference model plus directed expectations.
module tb_usr_shift_reg;
    import usr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        sin = 1'b0;
    logic [63:0] pdata = 64'd0;

    logic [3:0] q4;  logic [1:0] cnt4; logic msb4, lsb4, fd4;
    logic [7:0] q8;  logic [2:0] cnt8; logic msb8, lsb8, fd8;
    logic [4:0] q5;  logic [2:0] cnt5; logic msb5, lsb5, fd5;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    usr_shift_reg #(.WIDTH(4)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sin(sin),
        .i_pdata(pdata[3:0]), .o_q(q4), .o_sout_msb(msb4), .o_sout_lsb(lsb4),
        .o_bit_cnt(cnt4), .o_frame_done(fd4));

    usr_shift_reg #(.WIDTH(8), .RESET_VAL(64'h81)) u_w8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sin(sin),
        .i_pdata(pdata[7:0]), .o_q(q8), .o_sout_msb(msb8), .o_sout_lsb(lsb8),
        .o_bit_cnt(cnt8), .o_frame_done(fd8));

    usr_shift_reg #(.WIDTH(5)) u_w5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_sin(sin),
        .i_pdata(pdata[4:0]), .o_q(q5), .o_sout_msb(msb5), .o_sout_lsb(lsb5),
        .o_bit_cnt(cnt5), .o_frame_done(fd5));

    // Observed values, zero-extended so all widths compare uniformly.
    logic [63:0] obs_q[3];
    int          obs_cnt[3];
    logic        obs_fd[3], obs_msb[3], obs_lsb[3];

    always_comb begin
        obs_q[0] = 64'(q4); obs_cnt[0] = 32'(cnt4); obs_fd[0] = fd4; obs_msb[0] = msb4; obs_lsb[0] = lsb4;
        obs_q[1] = 64'(q8); obs_cnt[1] = 32'(cnt8); obs_fd[1] = fd8; obs_msb[1] = msb8; obs_lsb[1] = lsb8;
        obs_q[2] = 64'(q5); obs_cnt[2] = 32'(cnt5); obs_fd[2] = fd5; obs_msb[2] = msb5; obs_lsb[2] = lsb5;
    end

    // Reference model: register value as an integer, frame position as ops mod WIDTH.
    int          wid[3] = '{4, 8, 5};
    logic [63:0] rst_val[3] = '{64'd0, 64'h81, 64'd0};
    logic [63:0] m_q[3];
    int          m_cnt[3];
    logic        m_fd[3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k]   = rst_val[k];
            m_cnt[k] = 0;
            m_fd[k]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic e, input logic [2:0] m,
                                       input logic s, input logic [63:0] p);
        for (int k = 0; k < 3; k++) begin
            logic [63:0] mask;
            logic [63:0] q;
            logic        moved;
            mask  = (64'd1 << wid[k]) - 64'd1;
            q     = m_q[k];
            moved = 1'b0;
            m_fd[k] = 1'b0;
            if (e) begin
                case (m)
                    3'd1: begin q = ((q << 1) | 64'(s)) & mask; moved = 1'b1; end
                    3'd2: begin q = (q >> 1) | (64'(s) << (wid[k] - 1)); moved = 1'b1; end
                    3'd3: begin q = p & mask; m_cnt[k] = 0; end
                    3'd4: begin q = ((q << 1) | (q >> (wid[k] - 1))) & mask; moved = 1'b1; end
                    3'd5: begin q = (q >> 1) | ((q & 64'd1) << (wid[k] - 1)); moved = 1'b1; end
                    3'd6: begin q = 64'd0; m_cnt[k] = 0; end
                    default: ;
                endcase
            end
            if (moved) begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == wid[k]) begin
                    m_cnt[k] = 0;
                    m_fd[k]  = 1'b1;
                end
            end
            m_q[k] = q;
        end
    endfunction

    // Drive one operation, wait for its edge, advance the model; returns at edge+1.
    task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [63:0] p);
        en = e; mode = m; sin = s; pdata = p;
        @(posedge clk);
        #1;
        model_step(e, m, s, p);
    endtask

    task automatic test_reset();
        model_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++; if (obs_q[k] !== m_q[k]) begin miscompares++; $display("FAIL reset_q w%0d got %h want %h", wid[k], obs_q[k], m_q[k]); end
            vectors++; if (obs_cnt[k] !== 0) begin miscompares++; $display("FAIL reset_cnt w%0d got %0d want 0", wid[k], obs_cnt[k]); end
            vectors++; if (obs_fd[k] !== 1'b0) begin miscompares++; $display("FAIL reset_fd w%0d got %b want 0", wid[k], obs_fd[k]); end
        end
        $display("reset: q4=%h q8=%h q5=%h", q4, q8, q5);
    endtask

    task automatic test_shl_w4();
        logic [3:0] bits = 4'b1101;
        logic [3:0] exp_q[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        int         exp_c[4] = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, USR_SHL, bits[i], 64'd0);
            vectors++; if (q4 !== exp_q[i]) begin miscompares++; $display("FAIL shl4_q #%0d got %b want %b", i, q4, exp_q[i]); end
            vectors++; if (obs_cnt[0] !== exp_c[i]) begin miscompares++; $display("FAIL shl4_cnt #%0d got %0d want %0d", i, obs_cnt[0], exp_c[i]); end
            vectors++; if (fd4 !== (i == 3)) begin miscompares++; $display("FAIL shl4_fd #%0d got %b want %b", i, fd4, (i == 3)); end
            $display("shl4 #%0d sin=%b q=%b cnt=%0d fd=%b", i, bits[i], q4, cnt4, fd4);
        end
        step(1'b0, USR_HOLD, 1'b0, 64'd0);
        vectors++; if (fd4 !== 1'b0) begin miscompares++; $display("FAIL shl4_fd_after got %b want 0", fd4); end
    endtask

    task automatic test_rol_ror();
        int pulses = 0;
        step(1'b1, USR_LOAD, 1'b0, 64'hA5);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, USR_ROL, 1'b0, 64'd0);
            if (fd8) pulses++;
            if (i == 1) begin vectors++; if (q8 !== 8'h4B) begin miscompares++; $display("FAIL rol8_1 got %h want 4b", q8); end end
            if (i == 2) begin vectors++; if (q8 !== 8'h96) begin miscompares++; $display("FAIL rol8_2 got %h want 96", q8); end end
            for (int k = 0; k < 3; k++) begin
                vectors++; if (obs_q[k] !== m_q[k] || obs_fd[k] !== m_fd[k]) begin miscompares++; $display("FAIL rol_model w%0d #%0d q=%h fd=%b want q=%h fd=%b", wid[k], i, obs_q[k], obs_fd[k], m_q[k], m_fd[k]); end
            end
            $display("rol8 #%0d q=%h cnt=%0d fd=%b", i, q8, cnt8, fd8);
        end
        vectors++; if (q8 !== 8'hA5) begin miscompares++; $display("FAIL rol8_full got %h want a5", q8); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL rol8_pulses got %0d want 1", pulses); end
        step(1'b1, USR_ROR, 1'b0, 64'd0);
        vectors++; if (q8 !== 8'hD2) begin miscompares++; $display("FAIL ror8 got %h want d2", q8); end
        $display("ror8 q=%h cnt=%0d", q8, cnt8);
    endtask

    task automatic test_shr_load();
        logic [7:0] exp_q[3] = '{8'h80, 8'hC0, 8'hE0};
        step(1'b1, USR_CLEAR, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, USR_SHR, 1'b1, 64'd0);
            vectors++; if (q8 !== exp_q[i] || obs_cnt[1] !== i + 1 || fd8 !== 1'b0) begin miscompares++; $display("FAIL shr8 #%0d q=%h cnt=%0d fd=%b want q=%h cnt=%0d fd=0", i, q8, cnt8, fd8, exp_q[i], i + 1); end
            $display("shr8 #%0d q=%h cnt=%0d", i, q8, cnt8);
        end
        step(1'b1, USR_LOAD, 1'b0, 64'h3C);
        vectors++; if (q8 !== 8'h3C || obs_cnt[1] !== 0 || fd8 !== 1'b0) begin miscompares++; $display("FAIL load8 q=%h cnt=%0d fd=%b want q=3c cnt=0 fd=0", q8, cnt8, fd8); end
        $display("load8 q=%h cnt=%0d", q8, cnt8);
    endtask

    task automatic test_enable_hold();
        int pulses = 0;
        step(1'b1, USR_LOAD, 1'b0, 64'h16);
        step(1'b1, USR_SHL, 1'b1, 64'd0);
        step(1'b1, USR_SHL, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, USR_SHL, 1'b1, 64'd0);
            vectors++; if (q8 !== 8'h5A || obs_cnt[1] !== 2 || msb8 !== 1'b0 || lsb8 !== 1'b0 || fd8 !== 1'b0) begin miscompares++; $display("FAIL hold8 #%0d q=%h cnt=%0d msb=%b lsb=%b fd=%b want 5a/2/0/0/0", i, q8, cnt8, msb8, lsb8, fd8); end
            $display("hold8 #%0d q=%h cnt=%0d", i, q8, cnt8);
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, USR_SHL, 1'(i), 64'd0);
            if (fd8) pulses++;
            vectors++; if (fd8 !== (i == 6)) begin miscompares++; $display("FAIL resume8_fd #%0d got %b want %b", i, fd8, (i == 6)); end
            vectors++; if (obs_q[1] !== m_q[1]) begin miscompares++; $display("FAIL resume8_q #%0d got %h want %h", i, q8, m_q[1]); end
        end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL resume8_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_async_reset();
        step(1'b1, USR_LOAD, 1'b0, 64'hFF);
        for (int i = 0; i < 3; i++) step(1'b1, USR_ROL, 1'b0, 64'd0);
        vectors++; if (q8 !== 8'hFF || obs_cnt[1] !== 3) begin miscompares++; $display("FAIL areset_setup q=%h cnt=%0d want ff/3", q8, cnt8); end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++; if (q8 !== 8'h81 || obs_cnt[1] !== 0 || fd8 !== 1'b0) begin miscompares++; $display("FAIL areset8 q=%h cnt=%0d fd=%b want 81/0/0", q8, cnt8, fd8); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (obs_q[k] !== m_q[k] || obs_cnt[k] !== 0) begin miscompares++; $display("FAIL areset w%0d q=%h cnt=%0d want %h/0", wid[k], obs_q[k], obs_cnt[k], m_q[k]); end
        end
        $display("areset q8=%h cnt8=%0d", q8, cnt8);
        #1 rst_n = 1'b1;
        step(1'b1, USR_CLEAR, 1'b0, 64'd0);
        vectors++; if (q8 !== 8'h00 || fd8 !== 1'b0) begin miscompares++; $display("FAIL clear8 q=%h fd=%b want 00/0", q8, fd8); end
    endtask

    task automatic test_nonpow2();
        int n = 0;
        step(1'b1, USR_CLEAR, 1'b0, 64'd0);
        for (int i = 0; i < 11; i++) begin
            if (i == 3) begin
                logic [4:0] prev_q = q5;
                int         prev_c = obs_cnt[2];
                step(1'b1, USR_RSVD, 1'b1, 64'd0);
                vectors++; if (q5 !== prev_q || obs_cnt[2] !== prev_c || fd5 !== 1'b0) begin miscompares++; $display("FAIL rsvd5 q=%b cnt=%0d fd=%b want %b/%0d/0", q5, cnt5, fd5, prev_q, prev_c); end
            end else begin
                n++;
                step(1'b1, USR_SHL, 1'($urandom_range(0, 1)), 64'd0);
                vectors++; if (fd5 !== (n % 5 == 0)) begin miscompares++; $display("FAIL np2_fd shift%0d got %b want %b", n, fd5, (n % 5 == 0)); end
                vectors++; if (obs_cnt[2] !== n % 5 || obs_q[2] !== m_q[2]) begin miscompares++; $display("FAIL np2 shift%0d cnt=%0d q=%b want %0d/%b", n, cnt5, q5, n % 5, m_q[2][4:0]); end
            end
            $display("np2 #%0d mode=%0d q=%b cnt=%0d fd=%b", i, mode, q5, cnt5, fd5);
        end
    endtask

    task automatic test_back_to_back();
        int pulses[3] = '{0, 0, 0};
        int exp_p[3]  = '{4, 2, 3};
        step(1'b1, USR_LOAD, 1'b0, 64'h5B);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 2 == 0) ? USR_ROL : USR_SHR, 1'(i), 64'd0);
            for (int k = 0; k < 3; k++) begin
                if (obs_fd[k]) pulses[k]++;
                vectors++; if (obs_fd[k] !== m_fd[k] || obs_q[k] !== m_q[k]) begin miscompares++; $display("FAIL b2b w%0d #%0d q=%h fd=%b want %h/%b", wid[k], i, obs_q[k], obs_fd[k], m_q[k], m_fd[k]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (pulses[k] !== exp_p[k]) begin miscompares++; $display("FAIL b2b_pulses w%0d got %0d want %0d", wid[k], pulses[k], exp_p[k]); end
            $display("b2b w%0d pulses=%0d", wid[k], pulses[k]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic        e = ($urandom_range(0, 4) != 0);
            logic [2:0]  m = 3'($urandom_range(0, 7));
            logic        s = 1'($urandom_range(0, 1));
            logic [63:0] p = {$urandom, $urandom};
            step(e, m, s, p);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_q[k] !== m_q[k] || obs_cnt[k] !== m_cnt[k] || obs_fd[k] !== m_fd[k] ||
                    obs_msb[k] !== m_q[k][wid[k]-1] || obs_lsb[k] !== m_q[k][0]) begin
                    miscompares++;
                    $display("FAIL rand w%0d #%0d en=%b mode=%0d q=%h cnt=%0d fd=%b msb=%b lsb=%b want q=%h cnt=%0d fd=%b",
                             wid[k], i, e, m, obs_q[k], obs_cnt[k], obs_fd[k], obs_msb[k], obs_lsb[k], m_q[k], m_cnt[k], m_fd[k]);
                end
            end
            $display("rand #%0d en=%b mode=%0d sin=%b q4=%h q8=%h q5=%h", i, e, m, s, q4, q8, q5);
        end
    endtask

    initial begin
        #11;
        test_reset();
        #1 rst_n = 1'b1;
        test_shl_w4();
        test_rol_ror();
        test_shr_load();
        test_enable_hold();
        test_async_reset();
        test_nonpow2();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usr_shift_reg.md
Name: usr_shift_reg

Overview:
Parametrised universal shift register. Generalises the team's fixed 4-stage serial-in shift register to WIDTH bits.
- Adds parallel load, bidirectional shift, rotate and synchronous clear.
- Adds a shift counter with a one-cycle frame-done pulse.
- Used as the serialiser/deserialiser stage in front of the bootcamp peripheral blocks (UART-style TX/RX, SPI-style links).

Parameters:
WIDTH, 4, register width in bits; legal range 2..64
RESET_VAL, 0, value of o_q after reset; WIDTH bits, zero-extended/truncated
CNT_W, $clog2(WIDTH), bit-counter width; derived localparam, not overridable

Ports:
i_clk  input  1  rising-edge clock
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  operation enable; 0 forces HOLD regardless of i_mode
i_mode  input  3  operation select (encoding below)
i_sin  input  1  serial data in
i_pdata  input  WIDTH  parallel load data
o_q  output  WIDTH  register contents
o_sout_msb  output  1  equals o_q[WIDTH-1] (combinational from register)
o_sout_lsb  output  1  equals o_q[0] (combinational from register)
o_bit_cnt  output  CNT_W  number of shift/rotate ops since last LOAD/CLEAR/wrap
o_frame_done  output  1  registered one-cycle pulse on the WIDTH-th shift/rotate

Behaviour:
- Reset (i_rst_n=0, asynchronous, independent of clock): o_q=RESET_VAL, o_bit_cnt=0, o_frame_done=0. Deassertion takes effect at the next rising edge. Reset mid-frame discards the partial count.
- All updates occur on posedge i_clk when i_en=1. Latency is one cycle; o_q reflects the operation in the cycle after the edge.
- Mode encoding (i_en=1):
  - 0 HOLD: o_q unchanged
  - 1 SHL: o_q <= {o_q[WIDTH-2:0], i_sin}. With WIDTH=4 this is bit-exact with the legacy 4-stage register (q0 takes i_sin, qN takes old q(N-1)).
  - 2 SHR: o_q <= {i_sin, o_q[WIDTH-1:1]}
  - 3 LOAD: o_q <= i_pdata
  - 4 ROL: o_q <= {o_q[WIDTH-2:0], o_q[WIDTH-1]}
  - 5 ROR: o_q <= {o_q[0], o_q[WIDTH-1:1]}
  - 6 CLEAR: o_q <= 0 (not RESET_VAL)
  - 7 reserved: behaves as HOLD
- Bit counter:
  - SHL/SHR/ROL/ROR increment o_bit_cnt.
  - When o_bit_cnt==WIDTH-1 and a shift/rotate occurs: o_bit_cnt wraps to 0 and o_frame_done=1 for exactly that next cycle.
  - LOAD and CLEAR force o_bit_cnt=0 and suppress o_frame_done.
  - HOLD, reserved, and i_en=0 leave o_bit_cnt unchanged.
- o_frame_done is 0 in every cycle not described above. Back-to-back frames produce one pulse every WIDTH shifts with no dead cycle.
- Mixing directions inside a frame is legal; the counter counts operations, not direction.
- WIDTH not a power of two: wrap is at WIDTH-1, never at 2^CNT_W-1.
- Illegal/unknown i_mode (X) is not required to be handled. Assertions flag X on i_mode when i_en=1.

Decomposition:
- Package usr_pkg:
  - typedef enum logic [2:0] usr_mode_e (USR_HOLD, USR_SHL, USR_SHR, USR_LOAD, USR_ROL, USR_ROR, USR_CLEAR, USR_RSVD)
  - function usr_is_shift(usr_mode_e) returning 1 for SHL/SHR/ROL/ROR
- Sub-module usr_bit_counter (params MAX=WIDTH, W=CNT_W):
  - inputs inc, clr; outputs cnt, wrap_pulse.
  - Async active-low reset on the same i_clk/i_rst_n.
- Top holds the data register and the mode mux.

Test Plan:
1. Reset then WIDTH=4, SHL with i_sin sequence 1,0,1,1 -> o_q after each edge 0001,0010,0101,1011; o_bit_cnt 1,2,3,0; o_frame_done=1 only in the cycle after the 4th edge.
2. WIDTH=8, LOAD 8'hA5, then ROL x8 -> o_q returns to 8'hA5 after 8 rotates, intermediate 8'h4B,8'h96; one o_frame_done pulse; ROR x1 from 8'hA5 -> 8'hD2.
3. WIDTH=8, SHR with i_sin=1 from 8'h00 x3, then LOAD 8'h3C -> o_q 8'h80,8'hC0,8'hE0 then 8'h3C; o_bit_cnt 1,2,3 then 0; no o_frame_done.
4. i_en=0 with i_mode=SHL for 5 cycles mid-frame (cnt=2, o_q=8'h5A) -> o_q and o_bit_cnt frozen; o_sout_msb=0, o_sout_lsb=0; resume SHL completes frame after 6 more shifts with a single pulse.
5. Async reset asserted between clock edges at cnt=3, o_q=8'hFF, RESET_VAL=8'h81 -> o_q=8'h81 and cnt=0 immediately (before next edge); o_frame_done=0; CLEAR then gives 8'h00.
6. WIDTH=5 (non-power-of-two), 10 consecutive SHL -> pulses after 5th and 10th shifts only; o_bit_cnt never exceeds 4; mode 7 inserted mid-frame holds state.
